mpu_det_sequencer: RTL and testbench

MPU_DET_SEQUENCER -- requirements
Module: mpu_det_sequencer

---
 rtl/mpu_det_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_mpu_det_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_det_sequencer.sv
// mpu_det_sequencer
//
// Computes a Sarrus-style determinant over a small matrix held in a local
// register array. A single DET_W x DATA_W multiplier is reused every cycle.
// For each term it walks down the rows, multiplying one element per cycle
// (MUL). It then adds the finished product to the accumulator, or subtracts
// it (ACC).
//
// Term set for order n (K = n for n >= 3, K = 1 for n = 1, 2):
//   main      k = 0..K-1 : prod over i of m[i][(i+k) mod n]      (added)
//   secondary k = 0..K-1 : prod over i of m[i][(n-1-k-i) mod n]  (subtracted)
// Order 1 has no secondary term. All arithmetic is modulo 2^DET_W.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   wr_en    in   element write strobe (taken only while not busy)
//   wr_row   in   element row index (writes with index >= MAX_N are dropped)
//   wr_col   in   element column index (writes with index >= MAX_N are dropped)
//   wr_data  in   element value
//   size     in   matrix order n, sampled when start is accepted
//   start    in   request a computation (honoured in IDLE only)
//   busy     out  high while in MUL or ACC
//   done     out  one-cycle completion pulse (the DONE state)
//   err      out  last accepted request had size 0 or size > MAX_N
//   det      out  last computed determinant, held until the next accepted start
//
// Handshake: start is a single-cycle request. It is accepted on a rising
// edge where the FSM is IDLE; otherwise it is ignored. An accepted request
// always ends in exactly one done pulse, unless reset intervenes.
// det and err are valid from the done cycle onward.
module mpu_det_sequencer #(
  parameter int DATA_W = 8,
  parameter int DET_W  = 16,
  parameter int MAX_N  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [2:0]        wr_row,
  input  logic [2:0]        wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [7:0]        size,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DET_W-1:0]  det
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] mat_q [MAX_N][MAX_N];
  logic [2:0]        n_q;
  logic [2:0]        row_q;
  logic [2:0]        term_q;
  logic              pol_q;     // 0: main diagonal terms, 1: secondary
  logic [DET_W-1:0]  acc_q;
  logic [DET_W-1:0]  prod_q;

  // ---------------------------------------------------------------------
  // Element storage. Writes are blocked while a computation is running.
  // A write in the same cycle as an accepted start still commits, because
  // busy is low in IDLE, and MUL reads the array one cycle later.
  // ---------------------------------------------------------------------
  logic wr_ok;
  assign wr_ok = wr_en && !busy &&
                 (wr_row < 3'(MAX_N)) && (wr_col < 3'(MAX_N));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < MAX_N; r++) begin
        for (int c = 0; c < MAX_N; c++) begin
          mat_q[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      mat_q[wr_row][wr_col] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Column selection. Both sums are kept non-negative, so a single
  // conditional subtract of n gives the modulo:
  //   main      : i + k            in [0, 2n-2]
  //   secondary : 2n - 1 - k - i   in [1, 2n-1]  ( == n-1-k-i mod n )
  // ---------------------------------------------------------------------
  logic [3:0]        n_ext;
  logic [3:0]        main_sum;
  logic [3:0]        sec_sum;
  logic [3:0]        main_col;
  logic [3:0]        sec_col;
  logic [2:0]        col_sel;
  logic [DATA_W-1:0] elem;

  assign n_ext    = {1'b0, n_q};
  assign main_sum = {1'b0, row_q} + {1'b0, term_q};
  assign sec_sum  = {n_q, 1'b0} - 4'd1 - {1'b0, term_q} - {1'b0, row_q};
  assign main_col = (main_sum >= n_ext) ? main_sum - n_ext : main_sum;
  assign sec_col  = (sec_sum  >= n_ext) ? sec_sum  - n_ext : sec_sum;
  assign col_sel  = pol_q ? sec_col[2:0] : main_col[2:0];
  assign elem     = mat_q[row_q][col_sel];

  // Single shared multiplier, truncated to DET_W.
  logic [DET_W+DATA_W-1:0] mul_full;
  logic [DET_W-1:0]        prod_d;
  assign mul_full = {{DATA_W{1'b0}}, prod_q} * {{DET_W{1'b0}}, elem};
  assign prod_d   = mul_full[DET_W-1:0];

  logic [DET_W-1:0] acc_d;
  logic [2:0]       k_last;
  logic             last_row;
  logic             size_ok;

  assign acc_d    = pol_q ? (acc_q - prod_q) : (acc_q + prod_q);
  assign k_last   = (n_q >= 3'd3) ? (n_q - 3'd1) : 3'd0;
  assign last_row = (row_q == (n_q - 3'd1));
  assign size_ok  = (size >= 8'd1) && (size <= 8'(MAX_N));

  // ---------------------------------------------------------------------
  // Sequencer FSM. busy and done are registered alongside the state, so
  // they always reflect the state currently held.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      det     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      term_q  <= '0;
      pol_q   <= 1'b0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (size_ok) begin
              n_q     <= size[2:0];
              acc_q   <= '0;
              prod_q  <= DET_W'(1);
              row_q   <= '0;
              term_q  <= '0;
              pol_q   <= 1'b0;
              err     <= 1'b0;
              busy    <= 1'b1;
              state_q <= S_MUL;
            end else begin
              det     <= '0;
              err     <= 1'b1;
              done    <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end

        S_MUL: begin
          prod_q <= prod_d;
          row_q  <= row_q + 3'd1;
          if (last_row) begin
            state_q <= S_ACC;
          end
        end

        S_ACC: begin
          acc_q  <= acc_d;
          prod_q <= DET_W'(1);
          row_q  <= '0;
          if (term_q != k_last) begin
            term_q  <= term_q + 3'd1;
            state_q <= S_MUL;
          end else if (!pol_q && (n_q >= 3'd2)) begin
            // Main terms finished: switch to the secondary set.
            pol_q   <= 1'b1;
            term_q  <= '0;
            state_q <= S_MUL;
          end else begin
            det     <= acc_d;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_det_sequencer.sv
// Testbench for mpu_det_sequencer.
// Reference: a plain integer matrix plus a function that sums the Sarrus
// terms directly. Expected determinants pass through exp_q.
module tb_mpu_det_sequencer;

  localparam int DATA_W = 8;
  localparam int DET_W  = 16;
  localparam int MAX_N  = 5;
  localparam int TIMEOUT = 200;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [2:0]        wr_row = '0;
  logic [2:0]        wr_col = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [7:0]        size = '0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic              err;
  logic [DET_W-1:0]  det;

  always #5 clk = ~clk;

  mpu_det_sequencer #(.DATA_W(DATA_W), .DET_W(DET_W), .MAX_N(MAX_N)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .size    (size),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .det     (det)
  );

  // ---------------- scoreboard state ----------------
  int               checks = 0;
  int               errors = 0;
  int               mdl [MAX_N][MAX_N];
  logic [DET_W-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Determinant as defined by the Sarrus-style term rules.
  function automatic int model_det(input int n);
    int k_cnt, acc, p, c, npol;
    k_cnt = (n >= 3) ? n : 1;
    npol  = (n == 1) ? 1 : 2;
    acc   = 0;
    for (int pol = 0; pol < npol; pol++) begin
      for (int k = 0; k < k_cnt; k++) begin
        p = 1;
        for (int i = 0; i < n; i++) begin
          if (pol == 0) c = (i + k) % n;
          else          c = (((n - 1 - k - i) % n) + n) % n;
          p = (p * mdl[i][c]) & 32'hFFFF;
        end
        acc = (pol == 0) ? acc + p : acc - p;
      end
    end
    return acc & 32'hFFFF;
  endfunction

  function automatic int model_lat(input int n);
    int k_cnt;
    if (n < 1 || n > MAX_N) return 1;
    k_cnt = (n >= 3) ? n : 1;
    // n MUL cycles + 1 ACC cycle per term, then the DONE cycle
    return ((n == 1) ? 1 : 2 * k_cnt) * (n + 1) + 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_elem(input int r, input int c, input int v);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_row  = 3'(r);
    wr_col  = 3'(c);
    wr_data = 8'(v);
    @(negedge clk);
    wr_en   = 1'b0;
    if (r < MAX_N && c < MAX_N) mdl[r][c] = v & 32'hFF;
  endtask

  task automatic load_identity(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        set_elem(r, c, (r == c) ? 1 : 0);
  endtask

  task automatic load_random(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        set_elem(r, c, $urandom_range(0, 255));
  endtask

  // Issue start and follow the request to its done pulse.
  // disturb: write and restart attempts while busy (must be ignored).
  // wr_same: write m[0][0]=wv in the same cycle as start.
  task automatic run(input string tag, input int sz, input bit disturb,
                     input bit wr_same, input int wv);
    int  exp_err, exp_lat, lat, busy_bad;
    bit  seen;
    if (wr_same) mdl[0][0] = wv & 32'hFF;
    exp_err = (sz >= 1 && sz <= MAX_N) ? 0 : 1;
    exp_lat = model_lat(sz);
    exp_q.push_back(exp_err ? '0 : DET_W'(model_det(sz)));
    @(negedge clk);
    start = 1'b1;
    size  = 8'(sz);
    if (wr_same) begin
      wr_en = 1'b1; wr_row = 3'd0; wr_col = 3'd0; wr_data = 8'(wv);
    end
    lat = 0; seen = 1'b0; busy_bad = 0;
    while (!seen && lat < TIMEOUT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      if (disturb && lat == 10) begin
        wr_en = 1'b1; wr_row = 3'd0; wr_col = 3'd0; wr_data = 8'd7;
        start = 1'b1; size = 8'd2;
      end
      if (done) seen = 1'b1;
      else if (busy !== (exp_err == 0)) busy_bad++;
    end
    start = 1'b0;
    wr_en = 1'b0;
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_busy"}, busy_bad, 0);
    check_eq({tag, "_det"}, det, exp_q.pop_front());
    check_eq({tag, "_err"}, err, exp_err);
    check_eq({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, done, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, done_cnt;
    for (int r = 0; r < MAX_N; r++)
      for (int c = 0; c < MAX_N; c++)
        mdl[r][c] = 0;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_det", det, 0);
    rst = 1'b0;

    // 1x1 [9]
    set_elem(0, 0, 9);
    run("n1", 1, 0, 0, 0);
    check_eq("n1_value", det, 9);

    // [[3,4],[2,5]] -> 7
    set_elem(0, 0, 3); set_elem(0, 1, 4); set_elem(1, 0, 2); set_elem(1, 1, 5);
    run("n2", 2, 0, 0, 0);
    check_eq("n2_value", det, 7);

    // [[0,1],[1,0]] -> -1 wraps to FFFF
    set_elem(0, 0, 0); set_elem(0, 1, 1); set_elem(1, 0, 1); set_elem(1, 1, 0);
    run("n2_wrap", 2, 0, 0, 0);
    check_eq("n2_wrap_value", det, 16'hFFFF);

    load_identity(3);
    run("id3", 3, 0, 0, 0);
    check_eq("id3_value", det, 1);

    // Identity 5 with writes and a restart attempt while busy
    load_identity(5);
    run("id5_disturb", 5, 1, 0, 0);
    check_eq("id5_value", det, 1);
    run("id5_rerun", 5, 0, 0, 0);
    check_eq("id5_rerun_value", det, 1);

    // Invalid size, then a valid request clears err
    run("size6", 6, 0, 0, 0);
    run("size1_after_err", 1, 0, 0, 0);

    // Write in the same cycle as start is seen by the computation
    run("wr_same", 1, 0, 1, 11);
    check_eq("wr_same_value", det, 11);

    // Out-of-range writes are dropped
    load_random(5);
    set_elem(5, 0, 200); set_elem(0, 5, 201); set_elem(7, 7, 202);
    run("oob_wr", 5, 0, 0, 0);

    // Randomized requests, including invalid sizes
    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(6, 255);
      end else begin
        n = $urandom_range(1, MAX_N);
        load_random(n);
      end
      run($sformatf("rand%0d_n%0d", it, n), n, 0, 0, 0);
    end

    // Reset mid-computation
    load_identity(5);
    run("pre_rst", 5, 0, 0, 0);
    @(negedge clk);
    start = 1'b1; size = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_det", det, 0);
    check_eq("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < MAX_N; r++)
      for (int c = 0; c < MAX_N; c++)
        mdl[r][c] = 0;
    done_cnt = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_eq("midrst_no_done", done_cnt, 0);
    run("post_rst_cleared", 3, 0, 0, 0);
    load_random(5);
    run("post_rst_rerun", 5, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
